// File: rtl/usopenhpsdr1_pkg.sv
// Shared definitions for the OpenHPSDR protocol-1 upstream path.
// Used by the round assembler and, later, by the packer.
package usopenhpsdr1_pkg;

    localparam int unsigned SW     = 24;  // width of one I or Q word
    localparam int unsigned NR_MAX = 12;  // largest receiver count any build supports

    // Bit positions inside the 2-bit tuser sideband
    localparam int unsigned TUSER_VNA   = 0;
    localparam int unsigned TUSER_FIRST = 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

endpackage

// File: rtl/usiq_round_assembler_if.sv
// AXI-stream style word bus between the round assembler and the upstream sample FIFO.
interface usiq_round_assembler_if #(
    parameter int unsigned SW = usopenhpsdr1_pkg::SW
) ();

    logic [SW-1:0] us_tdata;
    logic          us_tvalid;
    logic          us_tready;
    logic          us_tlast;
    logic [1:0]    us_tuser;

    modport master (
        output us_tdata,
        output us_tvalid,
        output us_tlast,
        output us_tuser,
        input  us_tready
    );

    modport slave (
        input  us_tdata,
        input  us_tvalid,
        input  us_tlast,
        input  us_tuser,
        output us_tready
    );

endinterface

// File: rtl/usiq_round_assembler.sv
// Captures one I/Q sample set from all active receivers per strobe and serialises it
// as a round of words I0,Q0,I1,Q1,... with tlast on the final Q.
module usiq_round_assembler #(
    parameter int unsigned NR = 4,                      // receivers implemented, 1..NR_MAX
    parameter int unsigned SW = usopenhpsdr1_pkg::SW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [3:0]           nrx,
    input  logic                 vna,
    input  logic                 rx_strobe,
    input  logic [NR*SW-1:0]     rx_i,
    input  logic [NR*SW-1:0]     rx_q,
    input  logic                 vna_bit,
    usiq_round_assembler_if.master us,
    output logic                 overrun,
    output logic [7:0]           overrun_cnt
);

    import usopenhpsdr1_pkg::*;

    localparam logic [3:0] NrL = 4'(NR);

    state_e          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [4:0]      last_q, last_d;      // index of the final word, 2*cnt-1
    logic [NR*SW-1:0] i_bank_q, i_bank_d;
    logic [NR*SW-1:0] q_bank_q, q_bank_d;
    logic            vbit_q, vbit_d;
    logic [SW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [1:0]      tuser_q, tuser_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      ovr_cnt_q, ovr_cnt_d;

    logic [3:0]      cnt_eff;
    logic [4:0]      last_new;
    logic [4:0]      idx_nxt;
    logic            beat_done;
    logic            round_end;
    logic            start;
    logic            drop;

    // Word k of a round: I of receiver k/2 for even k, Q for odd k
    function automatic logic [SW-1:0] pick(input logic [NR*SW-1:0] iv,
                                           input logic [NR*SW-1:0] qv,
                                           input logic [4:0]       k);
        logic [SW-1:0] w;
        w = '0;
        for (int r = 0; r < int'(NR); r++) begin
            if (k[4:1] == 4'(r)) begin
                w = k[0] ? qv[r*SW +: SW] : iv[r*SW +: SW];
            end
        end
        return w;
    endfunction

    // Clamp the requested receiver count and derive handshake/round events
    always_comb begin
        if (nrx == 4'd0) begin
            cnt_eff = 4'd1;
        end else if (nrx > NrL) begin
            cnt_eff = NrL;
        end else begin
            cnt_eff = nrx;
        end
        last_new  = {cnt_eff, 1'b0} - 5'd1;
        idx_nxt   = idx_q + 5'd1;
        beat_done = (state_q == SEND) && tvalid_q && us.us_tready;
        round_end = beat_done && (idx_q == last_q);
        // A strobe coinciding with the final handshake chains into the next round
        start     = rx_strobe && run && ((state_q == IDLE) || round_end);
        drop      = rx_strobe && run && (state_q == SEND) && !round_end;
    end

    // Next-state, hold bank and registered output word
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        i_bank_d  = i_bank_q;
        q_bank_d  = q_bank_q;
        vbit_d    = vbit_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        overrun_d = overrun_q;
        ovr_cnt_d = ovr_cnt_q;

        case (state_q)
            IDLE: begin
            end
            SEND: begin
                if (beat_done) begin
                    if (round_end) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tuser_d  = 2'b00;
                    end else begin
                        idx_d                = idx_nxt;
                        tdata_d              = pick(i_bank_q, q_bank_q, idx_nxt);
                        tlast_d              = (idx_nxt == last_q);
                        tuser_d[TUSER_FIRST] = 1'b0;
                        tuser_d[TUSER_VNA]   = vbit_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Round start wins over the end-of-round return to IDLE
        if (start) begin
            state_d              = SEND;
            idx_d                = 5'd0;
            last_d               = last_new;
            i_bank_d             = rx_i;
            q_bank_d             = rx_q;
            vbit_d               = vna && vna_bit;
            tdata_d              = rx_i[SW-1:0];
            tvalid_d             = 1'b1;
            tlast_d              = 1'b0;  // a round always has at least two words
            tuser_d[TUSER_FIRST] = 1'b1;
            tuser_d[TUSER_VNA]   = vna && vna_bit;
        end

        if (drop) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset aborts any partial round immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 5'd0;
            last_q    <= 5'd0;
            i_bank_q  <= '0;
            q_bank_q  <= '0;
            vbit_q    <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 2'b00;
            overrun_q <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            i_bank_q  <= i_bank_d;
            q_bank_q  <= q_bank_d;
            vbit_q    <= vbit_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            overrun_q <= overrun_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign us.us_tdata  = tdata_q;
    assign us.us_tvalid = tvalid_q;
    assign us.us_tlast  = tlast_q;
    assign us.us_tuser  = tuser_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_usiq_round_assembler.sv
// Bench for usiq_round_assembler: a queue-based round model plus directed and random stimulus.
module tb_usiq_round_assembler;

    localparam int unsigned NR = 4;
    localparam int unsigned SW = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run;
    logic [3:0]       nrx;
    logic             vna;
    logic             rx_strobe;
    logic [NR*SW-1:0] rx_i;
    logic [NR*SW-1:0] rx_q;
    logic             vna_bit;
    logic             tready;
    logic             overrun;
    logic [7:0]       overrun_cnt;

    int checks = 0;
    int errors = 0;

    usiq_round_assembler_if #(.SW(SW)) us ();
    assign us.us_tready = tready;

    usiq_round_assembler #(.NR(NR), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .nrx         (nrx),
        .vna         (vna),
        .rx_strobe   (rx_strobe),
        .rx_i        (rx_i),
        .rx_q        (rx_q),
        .vna_bit     (vna_bit),
        .us          (us),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [SW-1:0] data;
        logic          last;
        logic [1:0]    user;
    } beat_t;

    beat_t       exp_q[$];
    logic        m_ovr;
    int unsigned m_ovr_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ovr     = 1'b0;
            m_ovr_cnt = 0;
        end else begin
            beat_t b;
            if (exp_q.size() > 0 && tready) b = exp_q.pop_front();
            if (rx_strobe && run) begin
                if (exp_q.size() == 0) begin
                    int n;
                    logic vb;
                    n  = (nrx == 0) ? 1 : ((int'(nrx) > int'(NR)) ? int'(NR) : int'(nrx));
                    vb = vna & vna_bit;
                    for (int r = 0; r < n; r++) begin
                        b.data = rx_i[r*SW +: SW];
                        b.last = 1'b0;
                        b.user = {(r == 0), vb};
                        exp_q.push_back(b);
                        b.data = rx_q[r*SW +: SW];
                        b.last = (r == n - 1);
                        b.user = {1'b0, vb};
                        exp_q.push_back(b);
                    end
                end else begin
                    m_ovr = 1'b1;
                    if (m_ovr_cnt < 255) m_ovr_cnt++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("tvalid", 32'(us.us_tvalid), 32'(exp_q.size() > 0));
            if (us.us_tvalid && exp_q.size() > 0) begin
                chk("tdata", 32'(us.us_tdata), 32'(exp_q[0].data));
                chk("tlast", 32'(us.us_tlast), 32'(exp_q[0].last));
                chk("tuser", 32'(us.us_tuser), 32'(exp_q[0].user));
            end
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr_cnt));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        rx_i = {$urandom, $urandom, $urandom};
        rx_q = {$urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        rx_strobe = 1'b0;
        tready    = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int beats;
        bit done;

        run = 1'b1; nrx = 4'd2; vna = 1'b0; vna_bit = 1'b0;
        rx_strobe = 1'b0; rx_i = '0; rx_q = '0; tready = 1'b1;

        // Reset values, asynchronously applied
        #1 rst = 1'b1;
        #1;
        chk("rst_tvalid", 32'(us.us_tvalid), 32'd0);
        chk("rst_tlast", 32'(us.us_tlast), 32'd0);
        chk("rst_tuser", 32'(us.us_tuser), 32'd0);
        chk("rst_tdata", 32'(us.us_tdata), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two receivers, known words, no stalls
        @(negedge clk);
        rx_i = {24'h0, 24'h0, 24'h000003, 24'h000001};
        rx_q = {24'h0, 24'h0, 24'h000004, 24'h000002};
        nrx = 4'd2;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("lit_valid", 32'(us.us_tvalid), 32'd1);
            chk("lit_data", 32'(us.us_tdata), 32'(b + 1));
            chk("lit_last", 32'(us.us_tlast), 32'(b == 3));
            chk("lit_first", 32'(us.us_tuser[1]), 32'(b == 0));
            @(negedge clk);
        end
        chk("lit_idle", 32'(us.us_tvalid), 32'd0);
        chk("lit_overrun", 32'(overrun), 32'd0);

        // Four receivers with tready toggling: 8 beats over 15 cycles
        rand_data();
        nrx = 4'd4;
        tready = 1'b0;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            tready = (cyc % 2 == 0);
            if (us.us_tvalid && tready && us.us_tlast) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_cycles", 32'(cyc), 32'd15);
        tready = 1'b1;
        @(negedge clk);

        // One receiver, strobe every other cycle: continuous, no drops
        nrx = 4'd1;
        for (int s = 0; s < 20; s++) begin
            rand_data();
            rx_strobe = 1'b1;
            @(negedge clk);
            rx_strobe = 1'b0;
            @(negedge clk);
        end
        chk("every2_overrun_cnt", 32'(overrun_cnt), 32'd0);
        repeat (3) @(negedge clk);
        // Strobe every cycle: every second one drops
        for (int s = 0; s < 20; s++) begin
            rand_data();
            rx_strobe = 1'b1;
            @(negedge clk);
        end
        rx_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("every1_overrun_cnt", 32'(overrun_cnt), 32'd10);
        chk("every1_overrun", 32'(overrun), 32'd1);
        do_reset();

        // VNA bit carried on every beat; nrx=0 treated as one receiver
        rand_data();
        nrx = 4'd0; vna = 1'b1; vna_bit = 1'b1;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0; vna = 1'b0; vna_bit = 1'b0;
        chk("vna_beat0_user", 32'(us.us_tuser), 32'h3);
        @(negedge clk);
        chk("vna_beat1_user", 32'(us.us_tuser), 32'h1);
        chk("vna_beat1_last", 32'(us.us_tlast), 32'd1);
        @(negedge clk);
        // nrx above NR clamps to NR
        rand_data();
        nrx = 4'd15;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        beats = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (us.us_tvalid) beats++;
            if (us.us_tvalid && us.us_tlast) done = 1'b1;
            @(negedge clk);
        end
        chk("clamp_beats", 32'(beats), 32'(2 * NR));

        // Run drops mid-round: round still completes, later strobes ignored
        rand_data();
        nrx = 4'd2;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        @(negedge clk);
        run = 1'b0;
        for (int s = 0; s < 6; s++) begin
            rand_data();
            rx_strobe = 1'b1;
            @(negedge clk);
        end
        rx_strobe = 1'b0;
        chk("run_off_overrun", 32'(overrun), 32'd0);
        chk("run_off_idle", 32'(us.us_tvalid), 32'd0);
        run = 1'b1;
        @(negedge clk);

        // Asynchronous reset at beat 2 while stalled
        rand_data();
        nrx = 4'd2;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_tvalid", 32'(us.us_tvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tready = 1'b1;
        rx_i = {24'h0, 24'h0, 24'h0, 24'hABCDEF};
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        chk("post_rst_first", 32'(us.us_tuser[1]), 32'd1);
        chk("post_rst_data", 32'(us.us_tdata), 32'hABCDEF);
        drain();

        // 300 forced overruns saturate the counter
        nrx = 4'd15;
        tready = 1'b0;
        rx_strobe = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 300; s++) @(negedge clk);
        rx_strobe = 1'b0;
        chk("sat_overrun_cnt", 32'(overrun_cnt), 32'd255);
        chk("sat_overrun", 32'(overrun), 32'd1);
        drain();
        do_reset();

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            rand_data();
            tready    = ($urandom_range(0, 3) != 0);
            rx_strobe = ($urandom_range(0, 5) == 0);
            run       = ($urandom_range(0, 7) != 0);
            nrx       = 4'($urandom_range(0, 15));
            vna       = 1'($urandom_range(0, 1));
            vna_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        run = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
